// File: rtl/func_check_pkg.sv
// Shared constants and state type for the exhaustive sweep checker of
// F = wx' + y'z' + w'z'.
package func_check_pkg;

  localparam int          VEC_W     = 4;
  localparam int          ERR_W     = 5;
  localparam int          NUM_VEC   = 16;
  localparam logic [15:0] GOLDEN_TT = 16'h1F55;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic golden_bit(input logic [VEC_W-1:0] idx);
    return GOLDEN_TT[idx];
  endfunction

endpackage

// File: rtl/func_sweep_checker_if.sv
// Signal bundle between the sweep checker (slave) and whoever starts it and
// supplies the response of the implementation under check (master).
interface func_sweep_checker_if;
  import func_check_pkg::*;

  logic                  start;
  logic                  dut_f;
  logic [VEC_W-1:0]      wxyz;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_W-1:0]      err_count;
  logic [VEC_W-1:0]      first_fail;
  logic                  first_fail_vld;

  modport master (
    output start, dut_f,
    input  wxyz, busy, done, pass, err_count, first_fail, first_fail_vld
  );

  modport slave (
    input  start, dut_f,
    output wxyz, busy, done, pass, err_count, first_fail, first_fail_vld
  );

endinterface

// File: rtl/func_sweep_checker_settle_timer.sv
// Settle down-counter: reloads while not settling, then counts to zero and
// flags expiry in the last settle cycle.
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] count,
  output logic       expired
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= 4'd0;
    else if (load)
      cnt <= count;
    else if (en && cnt != 4'd0)
      cnt <= cnt - 4'd1;
  end

  assign expired = en & ~load & (cnt == 4'd0);

endmodule

// File: rtl/func_sweep_checker.sv
// Exhaustive 16-vector sweep checker against F = wx' + y'z' + w'z'.
// Optional build macro FUNC_CHECK_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   SETTLE | wxyz held for SETTLE_CYCLES cycles while the DUT settles
//   SAMPLE | one cycle: compare dut_f, record errors, advance or finish
//   DONE   | results held; start begins a new sweep
module func_sweep_checker
  import func_check_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  func_sweep_checker_if.slave  bus
);

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(NUM_VEC);

  state_t           state;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_expired;
  logic             mismatch;
  logic             last_vec;
  logic             stop_now;
  logic [ERR_W-1:0] err_nxt;

  assign tmr_en   = (state == SETTLE);
  assign tmr_load = (state != SETTLE);

  settle_timer u_settle_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .count   (SETTLE_LOAD),
    .expired (tmr_expired)
  );

  assign mismatch = (bus.dut_f != golden_bit(bus.wxyz));
  assign last_vec = (bus.wxyz == VEC_W'(NUM_VEC - 1));
  assign err_nxt  = (mismatch && bus.err_count != ERR_MAX) ?
                    bus.err_count + ERR_W'(1) : bus.err_count;

`ifdef FUNC_CHECK_STOP_ON_FAIL_EN
  assign stop_now = last_vec | mismatch;
`else
  assign stop_now = last_vec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      bus.wxyz           <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.pass           <= 1'b0;
      bus.err_count      <= '0;
      bus.first_fail     <= '0;
      bus.first_fail_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state              <= SETTLE;
            bus.wxyz           <= '0;
            bus.busy           <= 1'b1;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.err_count      <= '0;
            bus.first_fail     <= '0;
            bus.first_fail_vld <= 1'b0;
          end
        end
        SETTLE: begin
          if (tmr_expired)
            state <= SAMPLE;
        end
        SAMPLE: begin
          bus.err_count <= err_nxt;
          if (mismatch && !bus.first_fail_vld) begin
            bus.first_fail     <= bus.wxyz;
            bus.first_fail_vld <= 1'b1;
          end
          // pass is decided from the post-sample count so it is valid with done
          if (stop_now) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            bus.pass <= (err_nxt == '0);
          end else begin
            state    <= SETTLE;
            bus.wxyz <= bus.wxyz + VEC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_func_sweep_checker.sv
// Randomized self-checking bench for func_sweep_checker; expectations come
// from the boolean formula and per-sweep mismatch bookkeeping.
module tb_func_sweep_checker;

  localparam int S = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] resp_tt;
  logic [15:0] gold_tt;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  func_sweep_checker_if bus ();

  assign bus.dut_f = resp_tt[bus.wxyz];

  func_sweep_checker #(.SETTLE_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic bit f_ref(input int i);
    bit w, x, y, z;
    w = ((i >> 3) & 1) != 0;
    x = ((i >> 2) & 1) != 0;
    y = ((i >> 1) & 1) != 0;
    z = (i & 1) != 0;
    return (w & !x) | (!y & !z) | (!w & !z);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wxyz"}, bus.wxyz, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_err"},  bus.err_count, 0);
    chk({tag, "_ff"},   bus.first_fail, 0);
    chk({tag, "_ffv"},  bus.first_fail_vld, 0);
  endtask

  task automatic run_sweep(input logic [15:0] tt, input bit spam);
    int mism, ff, exp_err, exp_len, exp_last, n, wx_bad, busy_bad;
    resp_tt = tt;
    mism = 0;
    ff   = -1;
    for (int i = 0; i < 16; i++) begin
      if (tt[i] != gold_tt[i]) begin
        mism++;
        if (ff < 0) ff = i;
      end
    end
`ifdef FUNC_CHECK_STOP_ON_FAIL_EN
    exp_err  = (mism > 0) ? 1 : 0;
    exp_last = (mism > 0) ? ff : 15;
`else
    exp_err  = mism;
    exp_last = 15;
`endif
    exp_len = (exp_last + 1) * (S + 1);

    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0; wx_bad = 0; busy_bad = 0;
    while (!bus.done && n < exp_len + 8) begin
      if (int'(bus.wxyz) != n / (S + 1)) wx_bad++;
      if (!bus.busy || bus.pass) busy_bad++;
      if (spam && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      n++;
    end
    chk("sweep_len", n, exp_len);
    chk("wxyz_seq", wx_bad, 0);
    chk("busy_seq", busy_bad, 0);
    chk("err_count", bus.err_count, exp_err);
    chk("ff_vld", bus.first_fail_vld, (mism > 0) ? 1 : 0);
    chk("first_fail", bus.first_fail, (mism > 0) ? ff : 0);
    chk("pass", bus.pass, (mism == 0) ? 1 : 0);
    chk("busy_end", bus.busy, 0);
    chk("wxyz_end", bus.wxyz, exp_last);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", bus.done, 1);
    chk("err_hold", bus.err_count, exp_err);
  endtask

  task automatic reset_mid_sweep();
    int n;
    resp_tt = 16'h0000;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 0;
    while (bus.wxyz != 4'd5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_vec5", (bus.wxyz == 4'd5) ? 1 : 0, 1);
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_idle_busy", bus.busy, 0);
    chk("midrst_idle_done", bus.done, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) gold_tt[i] = f_ref(i);
    resp_tt = gold_tt;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.done, 0);

    run_sweep(gold_tt, 1'b0);
    run_sweep(16'h0000, 1'b0);
    run_sweep(16'hFFFF, 1'b0);
    run_sweep(gold_tt, 1'b1);
    run_sweep(gold_tt ^ 16'h8000, 1'b1);

    reset_mid_sweep();
    run_sweep(gold_tt, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [15:0] tt;
      tt = 16'($urandom);
      if (k < 2) tt = gold_tt ^ (16'h1 << $urandom_range(0, 15));
      run_sweep(tt, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/func_sweep_checker.md
FUNC_SWEEP_CHECKER -- requirements
Module: func_sweep_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles each vector is held before sampling; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1: one-cycle request to begin a sweep.
REQ-005 SHALL have port dut_f, input, 1: response from the implementation under check.
REQ-006 SHALL have port wxyz, output, 4: vector driven to the DUT, bit3=w, bit2=x, bit1=y, bit0=z.
REQ-007 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-008 SHALL have port done, output, 1: sweep complete; stays high until the next accepted start or rst.
REQ-009 SHALL have port pass, output, 1: valid while done; 1 when err_count==0.
REQ-010 SHALL have port err_count, output, 5: number of mismatching vectors, 0..16.
REQ-011 SHALL have port first_fail, output, 4: index of the lowest failing vector; valid when first_fail_vld is high.
REQ-012 SHALL have port first_fail_vld, output, 1: at least one mismatch has been recorded.

Function
REQ-013 SHALL compare against the golden function F = wx' + y'z' + w'z'.
- Truth table over index {w,x,y,z} is 16'h1F55.
- Ones at indices 0, 2, 4, 6, 8, 9, 10, 11, 12.
REQ-014 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL behave as follows in IDLE and DONE:
- start=1 moves to SETTLE on the next edge.
- wxyz, err_count, first_fail and first_fail_vld clear on that edge.
- done deasserts on that edge.
REQ-016 SHALL hold wxyz constant for exactly SETTLE_CYCLES cycles in SETTLE, then enter SAMPLE.
REQ-017 SHALL do the following in SAMPLE, for one cycle:
- Compare dut_f with the golden bit at index wxyz.
- On mismatch, increment err_count.
- On the first mismatch only, load first_fail=wxyz and set first_fail_vld.
REQ-018 SHALL leave SAMPLE as follows:
- If wxyz<15: increment wxyz and return to SETTLE.
- If wxyz==15: go to DONE, with wxyz holding at 15.
REQ-019 SHALL give a sweep length of exactly 16*(SETTLE_CYCLES+1) cycles from the start edge to done rising.
REQ-020 SHALL ignore start while busy.
REQ-021 SHALL accept start in DONE, beginning a new sweep with the same timing as from IDLE.
REQ-022 SHALL assert busy exactly in states SETTLE and SAMPLE.
REQ-023 SHALL drive pass = done & (err_count==0); pass SHALL be 0 outside DONE.
REQ-024 SHALL never wrap err_count; the maximum value is 16.

Reset
REQ-025 SHALL, on rst, take effect on the next edge in any state, including mid-sweep:
- State goes to IDLE.
- wxyz=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, first_fail_vld=0.
REQ-026 SHALL give rst priority over a simultaneous start.

Configuration
REQ-027 SHALL, with macro FUNC_CHECK_STOP_ON_FAIL_EN defined, go from SAMPLE directly to DONE on the first mismatch:
- err_count=1.
- wxyz holds at the failing index.
REQ-028 SHALL, without FUNC_CHECK_STOP_ON_FAIL_EN, always sweep all 16 vectors.

Structure
REQ-029 SHALL place the following in shared package func_check_pkg:
- GOLDEN_TT = 16'h1F55.
- VEC_W = 4.
- The state enum type.
REQ-030 SHALL implement the settle countdown in sub-module settle_timer:
- Inputs: load, count value.
- Output: expired pulse.

Verification
REQ-031 SHALL cover a correct DUT (golden model), SETTLE_CYCLES=1:
- done rises 32 cycles after the start edge.
- pass=1, err_count=0, first_fail_vld=0.
REQ-032 SHALL cover dut_f stuck at 0: err_count=9, first_fail=0, pass=0.
REQ-033 SHALL cover dut_f stuck at 1: err_count=7, first_fail=1, pass=0.
REQ-034 SHALL cover rst asserted at vector 5 mid-sweep:
- Next cycle: all outputs 0, state IDLE.
- A following start produces a full clean sweep.
REQ-035 SHALL cover start pulses during busy: ignored, and sweep length unchanged at 16*(SETTLE_CYCLES+1).
REQ-036 SHALL cover FUNC_CHECK_STOP_ON_FAIL_EN with dut_f stuck at 0:
- done after 2*(SETTLE_CYCLES+1) cycles or fewer.
- err_count=1, first_fail=0, wxyz=0.
